// File: rtl/cp0_defs.sv
// Shared CP0 definitions: register numbers, exception codes and the
// bit positions of the SR and Cause fields.
package cp0_defs;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE_BIT     = 0;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IM_LSB     = 10;
  localparam int SR_IM_MSB     = 15;
  localparam int CAUSE_BD_BIT  = 31;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_IP_MSB  = 15;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_EXC_MSB = 6;

  // SR.EXL doubles as the exception-entry state
  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } exl_state_t;

  function automatic logic [31:0] epc_align(input logic [31:0] v);
    return {v[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_req_arb.sv
// Combinational arbitration of hardware interrupts against datapath
// exceptions; interrupts win and report ExcCode Int.
module cp0_req_arb
  import cp0_defs::*;
(
  input  logic [5:0] hw_int,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic [3:0] exc_in,
  output logic       req,
  output logic [4:0] exc_code_sel
);

  logic int_req;
  logic exc_req;

  assign int_req      = (|(hw_int & im)) & ie & ~exl;
  assign exc_req      = (exc_in != 4'd0) & ~exl;
  assign req          = int_req | exc_req;
  assign exc_code_sel = int_req ? EXC_INT : {1'b0, exc_in};

endmodule

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception/interrupt sink: holds SR/Cause/EPC, requests the
// pipeline flush/redirect on exception entry and services eret.
module cp0_exc_unit
  import cp0_defs::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL     = 32'h2024_0007,
  parameter logic [5:0]  IM_RESET     = 6'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [3:0]  exc_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        req,
  output logic [31:0] handler_pc,
  output logic [31:0] epc_out,
  output logic        exl
);

  exl_state_t  state_reg;
  logic [5:0]  im_reg;
  logic        ie_reg;
  logic        bd_reg;
  logic [5:0]  ip_reg;
  logic [4:0]  exc_code_reg;
  logic [31:0] epc_reg;

  logic        arb_req;
  logic [4:0]  exc_code_sel;
  logic        wr_sr;
  logic        wr_epc;

  assign exl = (state_reg == ST_HANDLER);

  cp0_req_arb u_arb (
    .hw_int       (hw_int),
    .im           (im_reg),
    .ie           (ie_reg),
    .exl          (exl),
    .exc_in       (exc_in),
    .req          (arb_req),
    .exc_code_sel (exc_code_sel)
  );

  // Gated by reset so a pending exc_in cannot re-raise req while held in reset
  assign req        = arb_req & ~reset;
  assign handler_pc = HANDLER_ADDR;

  assign wr_sr  = we && (cp0_addr == REG_SR);
  assign wr_epc = we && (cp0_addr == REG_EPC);

  assign epc_out = wr_epc ? epc_align(cp0_wdata) : epc_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_NORMAL;
      im_reg       <= IM_RESET;
      ie_reg       <= 1'b0;
      bd_reg       <= 1'b0;
      ip_reg       <= 6'd0;
      exc_code_reg <= 5'd0;
      epc_reg      <= 32'd0;
    end else begin
      ip_reg <= hw_int;
      if (arb_req) begin
        state_reg    <= ST_HANDLER;
        bd_reg       <= bd_in;
        epc_reg      <= bd_in ? (vpc - 32'd4) : vpc;
        exc_code_reg <= exc_code_sel;
      end else begin
        if (eret)
          state_reg <= ST_NORMAL;
        // An SR write alongside eret would fight over EXL, so eret wins it;
        // an EPC write does not overlap and still lands.
        if (wr_sr && !eret) begin
          im_reg    <= cp0_wdata[SR_IM_MSB:SR_IM_LSB];
          state_reg <= exl_state_t'(cp0_wdata[SR_EXL_BIT]);
          ie_reg    <= cp0_wdata[SR_IE_BIT];
        end
        if (wr_epc)
          epc_reg <= epc_align(cp0_wdata);
      end
    end
  end

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      REG_SR: begin
        cp0_rdata[SR_IM_MSB:SR_IM_LSB] = im_reg;
        cp0_rdata[SR_EXL_BIT]          = exl;
        cp0_rdata[SR_IE_BIT]           = ie_reg;
      end
      REG_CAUSE: begin
        cp0_rdata[CAUSE_BD_BIT]                = bd_reg;
        cp0_rdata[CAUSE_IP_MSB:CAUSE_IP_LSB]   = ip_reg;
        cp0_rdata[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc_code_reg;
      end
      REG_EPC:  cp0_rdata = epc_reg;
      REG_PRID: cp0_rdata = PRID_VAL;
      default:  cp0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed self-checking bench for cp0_exc_unit with hand-computed expectations.
module tb_cp0_exc_unit;
  import cp0_defs::*;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [3:0]  exc_in;
  logic [5:0]  hw_int;
  logic        eret;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;
  logic        exl;

  int n_checks = 0;
  int n_fail   = 0;

  cp0_exc_unit dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .cp0_addr   (cp0_addr),
    .cp0_wdata  (cp0_wdata),
    .cp0_rdata  (cp0_rdata),
    .vpc        (vpc),
    .bd_in      (bd_in),
    .exc_in     (exc_in),
    .hw_int     (hw_int),
    .eret       (eret),
    .req        (req),
    .handler_pc (handler_pc),
    .epc_out    (epc_out),
    .exl        (exl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    cp0_addr = addr;
    #1;
    check_eq(tag, cp0_rdata, exp);
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; cp0_addr = 5'd0; cp0_wdata = 32'd0; vpc = 32'd0;
    bd_in = 1'b0; exc_in = 4'd0; hw_int = 6'd0; eret = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (2) tick();
    reset = 1'b0;
    #1;
    $display("txn reset: checking post-reset state");
    check_eq("rst_exl", {31'd0, exl}, 32'd0);
    check_eq("rst_req", {31'd0, req}, 32'd0);
    check_eq("rst_epc_out", epc_out, 32'd0);
    check_eq("handler_pc", handler_pc, 32'h0000_4180);
    read_chk("rst_sr", REG_SR, 32'd0);
    read_chk("rst_cause", REG_CAUSE, 32'd0);
    read_chk("prid", REG_PRID, 32'h2024_0007);
    read_chk("unmapped", 5'd3, 32'd0);

    // mtc0 SR: IE=1, IM=0; also try writing read-only Cause (must be ignored)
    tick();
    $display("txn mtc0 SR=0x1");
    we = 1'b1; cp0_addr = REG_SR; cp0_wdata = 32'h0000_0001;
    tick();
    cp0_addr = REG_CAUSE; cp0_wdata = 32'hFFFF_FFFF;
    tick();
    we = 1'b0;
    read_chk("sr_ie", REG_SR, 32'h0000_0001);
    read_chk("cause_ro", REG_CAUSE, 32'd0);

    // 1: Overflow
    $display("txn Ov exc_in=%0d vpc=3010", EXC_OV);
    exc_in = EXC_OV[3:0]; vpc = 32'h3010; bd_in = 1'b0;
    #1;
    check_eq("ov_req", {31'd0, req}, 32'd1);
    tick();
    exc_in = 4'd0;
    #1;
    check_eq("ov_exl", {31'd0, exl}, 32'd1);
    check_eq("ov_req_masked", {31'd0, req}, 32'd0);
    read_chk("ov_cause", REG_CAUSE, 32'h0000_0030);
    read_chk("ov_epc", REG_EPC, 32'h0000_3010);

    // eret back to normal
    $display("txn eret");
    eret = 1'b1;
    #1;
    check_eq("eret_epc_out", epc_out, 32'h0000_3010);
    tick();
    eret = 1'b0;
    check_eq("eret_exl", {31'd0, exl}, 32'd0);

    // 2: AdES in delay slot
    $display("txn AdES bd=1 vpc=3020");
    exc_in = EXC_ADES[3:0]; vpc = 32'h3020; bd_in = 1'b1;
    #1;
    check_eq("ades_req", {31'd0, req}, 32'd1);
    tick();
    exc_in = 4'd0; bd_in = 1'b0;
    read_chk("ades_epc", REG_EPC, 32'h0000_301C);
    read_chk("ades_cause", REG_CAUSE, 32'h8000_0014);
    eret = 1'b1;
    tick();
    eret = 1'b0;

    // 3: interrupt vs exception tie
    $display("txn mtc0 SR=0x401 then Int/AdEL tie");
    we = 1'b1; cp0_addr = REG_SR; cp0_wdata = 32'h0000_0401;
    tick();
    we = 1'b0;
    read_chk("sr_401", REG_SR, 32'h0000_0401);
    hw_int = 6'b000001; exc_in = EXC_ADEL[3:0]; vpc = 32'h3040;
    #1;
    check_eq("tie_req", {31'd0, req}, 32'd1);
    tick();
    exc_in = 4'd0;
    read_chk("tie_cause", REG_CAUSE, 32'h0000_0400);
    read_chk("tie_epc", REG_EPC, 32'h0000_3040);

    // 4: masking while EXL=1
    tick();
    $display("txn masked exc_in=12 hw_int=3F");
    exc_in = EXC_OV[3:0]; hw_int = 6'h3F; vpc = 32'h5000;
    #1;
    check_eq("mask_req", {31'd0, req}, 32'd0);
    read_chk("ip_lag", REG_CAUSE, 32'h0000_0400);
    tick();
    check_eq("mask_exl", {31'd0, exl}, 32'd1);
    read_chk("mask_cause", REG_CAUSE, 32'h0000_FC00);
    read_chk("mask_epc", REG_EPC, 32'h0000_3040);

    // 5: mtc0 EPC + eret same cycle
    $display("txn mtc0 EPC=3003 + eret");
    exc_in = 4'd0; hw_int = 6'd0;
    we = 1'b1; cp0_addr = REG_EPC; cp0_wdata = 32'h0000_3003; eret = 1'b1;
    #1;
    check_eq("fwd_epc_out", epc_out, 32'h0000_3000);
    check_eq("fwd_no_wt", cp0_rdata, 32'h0000_3040);
    tick();
    we = 1'b0; eret = 1'b0;
    check_eq("fwd_exl", {31'd0, exl}, 32'd0);
    read_chk("fwd_epc", REG_EPC, 32'h0000_3000);

    // boundary: vpc=0 in delay slot wraps
    $display("txn RI bd=1 vpc=0");
    exc_in = EXC_RI[3:0]; vpc = 32'd0; bd_in = 1'b1;
    tick();
    exc_in = 4'd0; bd_in = 1'b0;
    read_chk("wrap_epc", REG_EPC, 32'hFFFF_FFFC);
    read_chk("wrap_cause", REG_CAUSE, 32'h8000_0028);

    // 6: async reset mid-handler
    $display("txn async reset mid-handler");
    exc_in = EXC_OV[3:0];
    #1;
    reset = 1'b1;
    #1;
    check_eq("arst_exl", {31'd0, exl}, 32'd0);
    check_eq("arst_req", {31'd0, req}, 32'd0);
    check_eq("arst_epc_out", epc_out, 32'd0);
    read_chk("arst_cause", REG_CAUSE, 32'd0);
    exc_in = 4'd0;
    tick();
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
